edge_pulse_multi: RTL and testbench

- Parametrised multi-channel edge-to-pulse generator; next generation of the single-bit rising-edge pulser.
- Per channel: synchroniser, debounce filter, and selectable edge mode (off/rise/fall/both).
- Output pulse width is configurable and retriggerable.
- Sits between raw asynchronous inputs (buttons, camera/IR strobes, sync lines) and the control FSMs that consume single-event strobes.

---
 rtl/edge_pulse_pkg.sv | 14 +
 rtl/edge_pulse_chan.sv | 98 +++++++++
 rtl/edge_pulse_multi.sv | 44 ++++
 tb/tb_edge_pulse_multi.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the multi-channel edge-to-pulse generator:
// edge mode encodings and the event counter width.
package edge_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel: synchroniser, debounce filter, edge qualify, retriggerable pulse.
// With EDGE_PULSE_CNT_EN defined, also a saturating count of qualified events.
module edge_pulse_chan
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1,
  parameter int PULSE_LEN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic [1:0]       mode,
  output logic             level,
  output logic             out
`ifdef EDGE_PULSE_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt
`endif
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] P_LOAD  = PW'(PULSE_LEN);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [DW-1:0]          dcnt;
  logic [PW-1:0]          pcnt;
  logic                   accept;
  logic                   rise_en;
  logic                   fall_en;
  logic                   qual;
  edge_mode_e             m;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync[0] <= in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // The edge is recognised on the same clock edge that level is updated.
  always_comb begin
    m       = edge_mode_e'(mode);
    rise_en = (m == MODE_RISE) || (m == MODE_BOTH);
    fall_en = (m == MODE_FALL) || (m == MODE_BOTH);
    accept  = (s != level) && (dcnt == DB_LAST);
    qual    = accept && (s ? rise_en : fall_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      dcnt  <= '0;
    end else if (s == level) begin
      dcnt  <= '0;
    end else if (dcnt == DB_LAST) begin
      level <= s;
      dcnt  <= '0;
    end else begin
      dcnt  <= dcnt + DW'(1);
    end
  end

  // Reload on every qualified event so overlapping events stretch the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      out  <= 1'b0;
    end else if (qual) begin
      pcnt <= P_LOAD;
      out  <= 1'b1;
    end else if (pcnt != '0) begin
      out  <= (pcnt > PW'(1));
      pcnt <= pcnt - PW'(1);
    end else begin
      out  <= 1'b0;
    end
  end

`ifdef EDGE_PULSE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt <= '0;
    end else if (qual && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/edge_pulse_multi.sv
// Multi-channel edge-to-pulse generator; slices the buses onto per-channel units.
// Define EDGE_PULSE_CNT_EN to add cnt_clr/cnt per-channel event counters.
module edge_pulse_multi
  import edge_pulse_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1,
  parameter int PULSE_LEN   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in,
  input  logic [2*CHANNELS-1:0]     mode,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       out
`ifdef EDGE_PULSE_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [CNT_W*CHANNELS-1:0] cnt
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_pulse_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE),
      .PULSE_LEN  (PULSE_LEN)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .in     (in[i]),
      .mode   (mode[2*i+1:2*i]),
      .level  (level[i]),
      .out    (out[i])
`ifdef EDGE_PULSE_CNT_EN
      ,
      .cnt_clr(cnt_clr),
      .cnt    (cnt[CNT_W*i +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_edge_pulse_multi.sv
// Randomised bench for edge_pulse_multi: a default instance and a
// deep-sync/debounce/long-pulse instance, both checked against a timeline model.
module tb_edge_pulse_multi;

  localparam int NCYC    = 3000;
  localparam int SAT_BEG = 1500;
  localparam int SAT_END = 2600;

  logic       clk = 1'b0;
  logic       reset;
  logic       cnt_clr;
  logic [3:0] in_a, in_b;
  logic [7:0] mode_a, mode_b;
  logic [3:0] level_a, level_b, out_a, out_b;
`ifdef EDGE_PULSE_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  edge_pulse_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE(1), .PULSE_LEN(1)
  ) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .mode(mode_a),
    .level(level_a), .out(out_a)
`ifdef EDGE_PULSE_CNT_EN
    , .cnt_clr(cnt_clr), .cnt(cnt_a)
`endif
  );

  edge_pulse_multi #(
    .CHANNELS(4), .SYNC_STAGES(3), .DEBOUNCE(4), .PULSE_LEN(5)
  ) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .mode(mode_b),
    .level(level_b), .out(out_b)
`ifdef EDGE_PULSE_CNT_EN
    , .cnt_clr(cnt_clr), .cnt(cnt_b)
`endif
  );

  // Model state: raw input history per edge, current level, edge of last event.
  logic inh[2][4][NCYC];
  int   lvl[2][4];
  int   last_ev[2][4];
  int   mcnt[2][4];
  int   rst_edge;
  int   sp[2], dp[2], pp[2];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic check(input string tag, input int t, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, t, got, exp);
  endtask

  // Synchronised value seen at edge tt: raw input from sp edges earlier, 0 if before reset.
  function automatic logic s_at(input int i, input int c, input int tt);
    if (tt - sp[i] > rst_edge) return inh[i][c][tt - sp[i]];
    return 1'b0;
  endfunction

  task automatic model_step(input int t);
    logic [3:0] iv;
    logic [1:0] mv;
    logic       flip, q;
    if (reset) rst_edge = t;
    for (int i = 0; i < 2; i++) begin
      iv = (i == 0) ? in_a : in_b;
      for (int c = 0; c < 4; c++) begin
        mv = (i == 0) ? mode_a[2*c +: 2] : mode_b[2*c +: 2];
        inh[i][c][t] = iv[c];
        if (reset) begin
          lvl[i][c] = 0; last_ev[i][c] = -1; mcnt[i][c] = 0;
        end else begin
          // Level flips once the synced value has disagreed for dp consecutive edges.
          flip = 1'b1;
          for (int k = 0; k < dp[i]; k++) begin
            if (t - k <= rst_edge) flip = 1'b0;
            else if (int'(s_at(i, c, t - k)) == lvl[i][c]) flip = 1'b0;
          end
          q = 1'b0;
          if (flip) begin
            lvl[i][c] = 1 - lvl[i][c];
            case (mv)
              2'b01:   q = (lvl[i][c] == 1);
              2'b10:   q = (lvl[i][c] == 0);
              2'b11:   q = 1'b1;
              default: q = 1'b0;
            endcase
          end
          if (q) last_ev[i][c] = t;
          if (cnt_clr) mcnt[i][c] = 0;
          else if (q && mcnt[i][c] < 255) mcnt[i][c]++;
        end
      end
    end
  endtask

  task automatic compare(input int t);
    logic [3:0]  el, eo;
    logic [31:0] ec;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        el[c] = (lvl[i][c] != 0);
        eo[c] = (last_ev[i][c] >= 0) && (t - last_ev[i][c] < pp[i]);
        ec[8*c +: 8] = 8'(mcnt[i][c]);
      end
      if (i == 0) begin
        check("level_a", t, 32'(level_a), 32'(el));
        check("out_a", t, 32'(out_a), 32'(eo));
`ifdef EDGE_PULSE_CNT_EN
        check("cnt_a", t, cnt_a, ec);
`endif
      end else begin
        check("level_b", t, 32'(level_b), 32'(el));
        check("out_b", t, 32'(out_b), 32'(eo));
`ifdef EDGE_PULSE_CNT_EN
        check("cnt_b", t, cnt_b, ec);
`endif
      end
    end
  endtask

  initial begin
    sp[0] = 2; dp[0] = 1; pp[0] = 1;
    sp[1] = 3; dp[1] = 4; pp[1] = 5;
    rst_edge = 0;
    reset = 1'b1; cnt_clr = 1'b0;
    in_a = '0; in_b = '0;
    mode_a = 8'($urandom); mode_b = 8'($urandom);
    for (int t = 0; t < NCYC; t++) begin
      @(negedge clk);
      if (t < 3) reset = 1'b1;
      else if (t >= SAT_BEG && t < SAT_END) reset = 1'b0;
      else reset = ($urandom_range(0, 249) == 0);
      cnt_clr = (t >= SAT_BEG && t < SAT_END) ? 1'b0 : ($urandom_range(0, 59) == 0);
      if (t >= SAT_BEG && t < SAT_END) begin
        // All channels of the fast instance toggle together, every event counted.
        mode_a = 8'hFF;
        if (t % 2 == 0) in_a = ~in_a;
      end else begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 3) == 0) in_a[c] = ~in_a[c];
          if ($urandom_range(0, 15) == 0) mode_a[2*c +: 2] = 2'($urandom);
        end
      end
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 3) == 0) in_b[c] = ~in_b[c];
        if ($urandom_range(0, 15) == 0) mode_b[2*c +: 2] = 2'($urandom);
      end
      @(posedge clk);
      model_step(t);
      #1;
      compare(t);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
